// File: rtl/qed_pkg.sv
// Shared types for the SQED duplicate sequencer: FSM state encoding,
// RV32I major opcodes and the original-to-duplicate register remap.
package qed_pkg;

   typedef enum logic [1:0] {
      ST_ORIG,
      ST_DUP,
      ST_WAIT,
      ST_CHECK
   } qed_state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Move every register field the opcode actually uses into the x16-x31
   // bank by setting its top bit; immediates sharing those bit positions
   // are left alone because the opcode says they are not registers.
   function automatic logic [31:0] qed_remap(input logic [31:0] inst);
      logic [6:0]  opc;
      logic [31:0] res;
      opc = inst[6:0];
      res = inst;
      if (opc != OPC_STORE && opc != OPC_BRANCH)
         res[11] = 1'b1;
      if (!(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL}))
         res[19] = 1'b1;
      if (opc inside {OPC_OP, OPC_STORE, OPC_BRANCH})
         res[24] = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/qed_dup_sequencer_if.sv
// Fetch-side and decode-side valid/ready handshakes of the duplicate
// sequencer. The sequencer is the slave; fetch/decode (or a bench) is master.
interface qed_dup_sequencer_if;

   logic [31:0] in_inst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_inst;
   logic        out_valid;
   logic        out_ready;
   logic        out_is_dup;

   modport master (
      output in_inst, in_valid, out_ready,
      input  in_ready, out_inst, out_valid, out_is_dup
   );

   modport slave (
      input  in_inst, in_valid, out_ready,
      output in_ready, out_inst, out_valid, out_is_dup
   );

endinterface

// File: rtl/qed_inst_buffer.sv
// Circular instruction buffer holding the originals of one round until they
// are replayed as duplicates. Occupancy is owned by the caller's counters;
// this block only tracks head/tail and the storage.
module qed_inst_buffer #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic [31:0] head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;

   // Next pointers; DEPTH is a power of two so plain increment wraps.
   // NOTE: every always_comb variable is given a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (clr) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (push) tail_d = tail_q + AW'(1);
         if (pop)  head_d = head_q + AW'(1);
      end
   end

   // Pointer registers with synchronous reset.
   // NOTE: state is updated with non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Storage write.
   // NOTE: the array is deliberately not reset; an entry is only read after
   // it has been pushed in the current round, so reset would buy nothing.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= push_data;
   end

   assign head_data = mem_q[head_q];

endmodule

// File: rtl/qed_dup_sequencer.sv
// SQED instruction-side producer: forwards originals (x0-x15) to decode while
// recording them, replays them remapped to x16-x31, then waits for the core to
// drain and pulses the register-match check enable.
// Build option: define QED_AUTO_DUP_EN to start the duplicate phase
// automatically whenever the buffer fills.
module qed_dup_sequencer
   import qed_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   qed_dup_sequencer_if.slave  bus,
   input  logic                exec_dup,
   input  logic                core_idle,
   output logic                wait_till_commit,
   output logic                wait_till_commit_reg,
   output logic                chk_en,
   output logic [CW-1:0]       num_orig_insts,
   output logic [CW-1:0]       num_dup_insts
);

   qed_state_e  state_q, state_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic        out_valid_q, out_valid_d;
   logic        out_is_dup_q, out_is_dup_d;
   logic [CW-1:0] num_orig_q, num_orig_d;
   logic [CW-1:0] num_dup_q, num_dup_d;
   logic        wtc_q, wtc_d;
   logic        wtc_reg_q, wtc_reg_d;
   logic        chk_en_q, chk_en_d;

   logic [CW-1:0] occupancy;
   logic        buf_full, buf_empty;
   logic        out_free, in_ready_w, accept, pop, clr, auto_dup;
   logic [31:0] head_data;

   // Occupancy comes from the counters; head == tail is ambiguous when full.
   assign occupancy  = num_orig_q - num_dup_q;
   assign buf_full   = (num_orig_q == CW'(DEPTH));
   assign buf_empty  = (occupancy == '0);
   assign out_free   = !out_valid_q || bus.out_ready;
   assign in_ready_w = !rst && (state_q == ST_ORIG) && out_free && !buf_full;
   assign accept     = bus.in_valid && in_ready_w;
   assign pop        = (state_q == ST_DUP) && out_free && !buf_empty;
   assign clr        = (state_q == ST_CHECK);

`ifdef QED_AUTO_DUP_EN
   assign auto_dup = buf_full;
`else
   assign auto_dup = 1'b0;
`endif

   qed_inst_buffer #(.DEPTH(DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (accept),
      .pop       (pop),
      .push_data (bus.in_inst),
      .head_data (head_data)
   );

   // Next-state, output-register and counter logic for one round.
   // NOTE: combinational logic uses blocking assignments so later statements
   // see the values computed above them within the same evaluation.
   always_comb begin
      state_d      = state_q;
      out_inst_d   = out_inst_q;
      out_valid_d  = out_valid_q;
      out_is_dup_d = out_is_dup_q;
      num_orig_d   = num_orig_q;
      num_dup_d    = num_dup_q;

      // Skid stage: refill only when the current word is gone or leaving.
      if (out_free) begin
         out_valid_d = 1'b0;
         if (accept) begin
            out_inst_d   = bus.in_inst;
            out_is_dup_d = 1'b0;
            out_valid_d  = 1'b1;
         end else if (pop) begin
            out_inst_d   = qed_remap(head_data);
            out_is_dup_d = 1'b1;
            out_valid_d  = 1'b1;
         end
      end

      case (state_q)
         ST_ORIG: begin
            if (accept) num_orig_d = num_orig_q + CW'(1);
            // An accept coinciding with exec_dup lands first, so the buffer
            // is guaranteed non-empty on entry to DUP.
            if ((exec_dup && (accept || !buf_empty)) || auto_dup)
               state_d = ST_DUP;
         end
         ST_DUP: begin
            if (pop) begin
               num_dup_d = num_dup_q + CW'(1);
               if (occupancy == CW'(1)) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!out_valid_q && core_idle) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d    = ST_ORIG;
            num_orig_d = '0;
            num_dup_d  = '0;
         end
         default: state_d = ST_ORIG;
      endcase

      // Commit-wait only once the last duplicate has left the skid stage.
      wtc_d     = (state_d == ST_WAIT) && !out_valid_d;
      wtc_reg_d = wtc_q;
      chk_en_d  = (state_d == ST_CHECK);
   end

   // FSM and registered outputs, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ORIG;
         out_inst_q   <= '0;
         out_valid_q  <= 1'b0;
         out_is_dup_q <= 1'b0;
         num_orig_q   <= '0;
         num_dup_q    <= '0;
         wtc_q        <= 1'b0;
         wtc_reg_q    <= 1'b0;
         chk_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_inst_q   <= out_inst_d;
         out_valid_q  <= out_valid_d;
         out_is_dup_q <= out_is_dup_d;
         num_orig_q   <= num_orig_d;
         num_dup_q    <= num_dup_d;
         wtc_q        <= wtc_d;
         wtc_reg_q    <= wtc_reg_d;
         chk_en_q     <= chk_en_d;
      end
   end

   assign bus.in_ready         = in_ready_w;
   assign bus.out_inst         = out_inst_q;
   assign bus.out_valid        = out_valid_q;
   assign bus.out_is_dup       = out_is_dup_q;
   assign wait_till_commit     = wtc_q;
   assign wait_till_commit_reg = wtc_reg_q;
   assign chk_en               = chk_en_q;
   assign num_orig_insts       = num_orig_q;
   assign num_dup_insts        = num_dup_q;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Self-checking bench for qed_dup_sequencer. The reference model treats a
// round as a list: decode must see every original in order, then every
// original again with its register operands moved up by 16, then exactly one
// check pulse with both counts equal to the list length.
module tb_qed_dup_sequencer;
   import qed_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          exec_dup, core_idle;
   logic          wtc, wtc_reg, chk_en;
   logic [CW-1:0] num_orig, num_dup;

   qed_dup_sequencer_if bus ();

   qed_dup_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .bus                  (bus),
      .exec_dup             (exec_dup),
      .core_idle            (core_idle),
      .wait_till_commit     (wtc),
      .wait_till_commit_reg (wtc_reg),
      .chk_en               (chk_en),
      .num_orig_insts       (num_orig),
      .num_dup_insts        (num_dup)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0]   stim [$];
   logic [32:0]   got [$];
   int            chk_cnt, wtc_cnt, wtc_bad, inv_bad;
   logic [CW-1:0] chk_orig, chk_dup;
   logic          chk_wtcr, last_accept;

   // Duplicate of an original: each register operand the opcode uses is
   // renamed xN -> x(N+16); everything else is copied.
   function automatic logic [31:0] model_dup(input logic [31:0] inst);
      logic [6:0]  opc;
      logic [31:0] r;
      int          rd, rs1, rs2;
      opc = inst[6:0];
      rd  = int'(inst[11:7]);
      rs1 = int'(inst[19:15]);
      rs2 = int'(inst[24:20]);
      if (opc != OPC_STORE && opc != OPC_BRANCH) rd = 16 + rd % 16;
      if (opc != OPC_LUI && opc != OPC_AUIPC && opc != OPC_JAL) rs1 = 16 + rs1 % 16;
      if (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH) rs2 = 16 + rs2 % 16;
      r = inst;
      r[11:7]  = 5'(rd);
      r[19:15] = 5'(rs1);
      r[24:20] = 5'(rs2);
      return r;
   endfunction

   // Random original: any of the nine opcodes, register fields in x0-x15.
   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 8))
         0: r[6:0] = OPC_OP;
         1: r[6:0] = OPC_OP_IMM;
         2: r[6:0] = OPC_LOAD;
         3: r[6:0] = OPC_STORE;
         4: r[6:0] = OPC_BRANCH;
         5: r[6:0] = OPC_LUI;
         6: r[6:0] = OPC_AUIPC;
         7: r[6:0] = OPC_JAL;
         default: r[6:0] = OPC_JALR;
      endcase
      r[11] = 1'b0;
      r[19] = 1'b0;
      r[24] = 1'b0;
      return r;
   endfunction

   // One clock: observe at the falling edge, return just after the rising one.
   task automatic tick();
      @(negedge clk);
      last_accept = 1'b0;
      if (!rst) begin
         last_accept = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) got.push_back({bus.out_is_dup, bus.out_inst});
         if (chk_en) begin
            chk_cnt++;
            chk_orig = num_orig;
            chk_dup  = num_dup;
            chk_wtcr = wtc_reg;
         end
         if (wtc) begin
            wtc_cnt++;
            if (bus.out_valid) wtc_bad++;
         end
         if (num_dup > num_orig || num_orig > CW'(DEPTH)) inv_bad++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_round();
      got.delete();
      chk_cnt = 0;
      wtc_cnt = 0;
      wtc_bad = 0;
   endtask

   task automatic fill_random(input int n);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(rand_inst());
   endtask

   // Offer every stimulus word until it is accepted, with random gaps.
   task automatic push_stim(input int rdy_pct);
      foreach (stim[i]) begin
         int budget;
         budget = 0;
         bus.in_inst = stim[i];
         last_accept = 1'b0;
         while (!last_accept) begin
            if (budget++ > 200) begin
               vectors++;
               miscompares++;
               $display("FAIL push_timeout: word %0d not accepted, required accept within 200 cycles", i);
               bus.in_valid = 1'b0;
               return;
            end
            bus.in_valid  = ($urandom_range(0, 99) < 80);
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            tick();
         end
      end
      bus.in_valid = 1'b0;
   endtask

   // Optionally request the duplicate phase, then drain until the check pulse.
   task automatic finish_round(input bit pulse, input int rdy_pct);
      int budget;
      bus.in_valid = 1'b0;
      if (pulse) begin
         exec_dup      = 1'b1;
         bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
         tick();
         exec_dup = 1'b0;
      end
      budget = 0;
      while (chk_cnt == 0) begin
         if (budget++ > 500) begin
            vectors++;
            miscompares++;
            $display("FAIL chk_timeout: chk_en count %0d, required 1 within 500 cycles", chk_cnt);
            break;
         end
         bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
         if (wtc_cnt > 0 && $urandom_range(0, 2) == 0) core_idle = 1'b1;
         tick();
      end
      core_idle     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
   endtask

   // Compare one observed round against the list model.
   task automatic score_round(input string name);
      logic [32:0] exp_q [$];
      int n;
      n = stim.size();
      foreach (stim[i]) exp_q.push_back({1'b0, stim[i]});
      foreach (stim[i]) exp_q.push_back({1'b1, model_dup(stim[i])});
      vectors++;
      if (got.size() !== 2 * n) begin
         miscompares++;
         $display("FAIL %s_count: %0d words seen, required %0d", name, got.size(), 2 * n);
      end
      for (int i = 0; i < 2 * n && i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s_word%0d: dup/inst %h, required %h", name, i, got[i], exp_q[i]);
         end
      end
      vectors++;
      if (chk_cnt !== 1 || chk_orig !== CW'(n) || chk_dup !== CW'(n) || chk_wtcr !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_check: pulses %0d orig %0d dup %0d wtc_reg %b, required 1 %0d %0d 1",
                  name, chk_cnt, chk_orig, chk_dup, chk_wtcr, n, n);
      end
      vectors++;
      if (wtc_cnt == 0 || wtc_bad !== 0) begin
         miscompares++;
         $display("FAIL %s_wtc: high %0d cycles, %0d with output busy, required >0 and 0", name, wtc_cnt, wtc_bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      exec_dup = 1'b0;
      core_idle = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_inst = '0;
      bus.out_ready = 1'b0;
      inv_bad = 0;
      repeat (3) tick();
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.out_is_dup, wtc, wtc_reg, chk_en} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: %b, required 000000",
                  {bus.in_ready, bus.out_valid, bus.out_is_dup, wtc, wtc_reg, chk_en});
      end
      vectors++;
      if (bus.out_inst !== 32'h0 || num_orig !== '0 || num_dup !== '0) begin
         miscompares++;
         $display("FAIL reset_data: inst %h orig %0d dup %0d, required 0 0 0", bus.out_inst, num_orig, num_dup);
      end
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: in_ready %b out_valid %b, required 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_basic();
      stim.delete();
      stim.push_back(32'h002081B3);   // add x3,x1,x2 -> add x19,x17,x18
      start_round();
      push_stim(100);
      finish_round(1'b1, 100);
      score_round("basic");
   endtask

   task automatic test_remap();
      stim.delete();
      stim.push_back(32'h0020A023);   // sw x2,0(x1)
      stim.push_back(32'h000012B7);   // lui x5,1
      start_round();
      push_stim(100);
      finish_round(1'b1, 100);
      score_round("remap");
      if (got.size() == 4) begin
         vectors++;
         if (got[2] !== {1'b1, 32'h0128A023} || got[3] !== {1'b1, 32'h00001AB7}) begin
            miscompares++;
            $display("FAIL remap_literal: %h %h, required 10128a023 100001ab7", got[2], got[3]);
         end
      end
   endtask

   task automatic test_full_buffer();
      int dups;
      fill_random(DEPTH);
      start_round();
      push_stim(100);
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_ready: in_ready %b, required 0", bus.in_ready);
      end
`ifdef QED_AUTO_DUP_EN
      finish_round(1'b0, 100);
`else
      bus.in_valid  = 1'b1;
      bus.in_inst   = rand_inst();
      bus.out_ready = 1'b1;
      repeat (5) begin
         tick();
         vectors++;
         if (bus.in_ready !== 1'b0 || num_dup !== '0 || num_orig !== CW'(DEPTH)) begin
            miscompares++;
            $display("FAIL full_hold: in_ready %b dup %0d orig %0d, required 0 0 %0d",
                     bus.in_ready, num_dup, num_orig, DEPTH);
         end
      end
      dups = 0;
      foreach (got[i]) if (got[i][32]) dups++;
      vectors++;
      if (dups !== 0) begin
         miscompares++;
         $display("FAIL full_nodup: %0d duplicates issued, required 0", dups);
      end
      finish_round(1'b1, 100);
`endif
      score_round("full");
   endtask

   task automatic test_backpressure();
      fill_random(4);
      start_round();
      push_stim(100);
      bus.out_ready = 1'b1;
      exec_dup = 1'b1;
      tick();
      exec_dup = 1'b0;
      repeat (2) tick();
      bus.out_ready = 1'b0;
      repeat (3) begin
         tick();
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.out_is_dup !== 1'b1 ||
             bus.out_inst !== model_dup(stim[1]) || num_dup !== CW'(2)) begin
            miscompares++;
            $display("FAIL bp_hold: valid %b dup %b inst %h count %0d, required 1 1 %h 2",
                     bus.out_valid, bus.out_is_dup, bus.out_inst, num_dup, model_dup(stim[1]));
         end
      end
      finish_round(1'b0, 100);
      score_round("backpressure");
   endtask

   task automatic test_reset_mid_dup();
      fill_random(4);
      start_round();
      push_stim(100);
      bus.out_ready = 1'b1;
      exec_dup = 1'b1;
      tick();
      exec_dup = 1'b0;
      repeat (3) tick();
      vectors++;
      if (got.size() !== 6) begin
         miscompares++;
         $display("FAIL rstdup_pre: %0d words before reset, required 6", got.size());
      end
      rst = 1'b1;
      tick();
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.out_is_dup, wtc, wtc_reg, chk_en} !== 6'b0 ||
          bus.out_inst !== 32'h0 || num_orig !== '0 || num_dup !== '0) begin
         miscompares++;
         $display("FAIL rstdup_state: flags %b inst %h orig %0d dup %0d, required all 0",
                  {bus.in_ready, bus.out_valid, bus.out_is_dup, wtc, wtc_reg, chk_en},
                  bus.out_inst, num_orig, num_dup);
      end
      rst = 1'b0;
      fill_random(3);
      start_round();
      push_stim(60);
      finish_round(1'b1, 60);
      score_round("after_reset");
   endtask

   task automatic test_empty_and_wrap();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      exec_dup = 1'b1;
      repeat (3) begin
         tick();
         vectors++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || num_orig !== '0) begin
            miscompares++;
            $display("FAIL empty_req: in_ready %b out_valid %b orig %0d, required 1 0 0",
                     bus.in_ready, bus.out_valid, num_orig);
         end
      end
      exec_dup = 1'b0;
      for (int r = 0; r < 2; r++) begin
         fill_random(10);
         start_round();
         push_stim(70);
         finish_round(1'b1, 70);
         score_round("wrap");
      end
   endtask

   task automatic test_random_rounds();
      for (int r = 0; r < 6; r++) begin
         int pct;
         pct = $urandom_range(40, 100);
         fill_random($urandom_range(1, DEPTH));
         start_round();
         push_stim(pct);
         finish_round(1'b1, pct);
         score_round("random");
      end
      vectors++;
      if (inv_bad !== 0) begin
         miscompares++;
         $display("FAIL invariant: %0d cycles with dup>orig or orig>DEPTH, required 0", inv_bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_remap();
      test_full_buffer();
      test_backpressure();
      test_reset_mid_dup();
      test_empty_and_wrap();
      test_random_rounds();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
